// File: rtl/fetch_unit_if.sv
// Instruction-memory read port between the fetch stage and instruction memory.
interface fetch_unit_if;
  logic        ihit;
  logic [31:0] iload;
  logic        imemREN;
  logic [31:0] imemaddr;

  // Fetch stage issues reads and consumes returned words.
  modport master (input ihit, input iload, output imemREN, output imemaddr);
  // Instruction memory answers reads.
  modport slave  (output ihit, output iload, input imemREN, input imemaddr);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage with PC, redirect/stall handling and IF/ID latch.
module fetch_unit #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RST,
  fetch_unit_if.master     imem,
  input  logic             mem_stall,
  input  logic             lw_nop,
  input  logic             halt,
  input  logic [1:0]       pcsrc,
  input  logic [31:0]      jr_addr,
  input  logic [31:0]      br_target,
  input  logic [25:0]      j_imm,
  input  logic [31:0]      ex_npc,
  output logic [31:0]      ifid_instr,
  output logic [31:0]      ifid_npc,
  output logic             ifid_valid,
  output logic [31:0]      pc_out,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int unsigned XLEN = 32;

  typedef enum logic {FETCH, HALTED} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  instr_q, instr_d;
  logic [XLEN-1:0]  npc_q, npc_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  redir_tgt;
  logic [XLEN-1:0]  pc_plus4;
  logic [CNT_W-1:0] cnt_sat_inc;
  logic             unused_ex_npc;

  // Only the region bits of ex_npc take part in a J target.
  assign unused_ex_npc = ^ex_npc[27:0];

  // Read address tracks pc; reads stop once halted.
  assign imem.imemaddr = pc_q;
  assign imem.imemREN  = (state_q == FETCH);

  assign ifid_instr = instr_q;
  assign ifid_npc   = npc_q;
  assign ifid_valid = valid_q;
  assign pc_out     = pc_q;
  assign stall_cnt  = cnt_q;

  assign pc_plus4 = pc_q + XLEN'(4);

  // Redirect target selection, always word aligned.
  always_comb begin
    redir_tgt = pc_plus4;
    case (pcsrc)
      2'b01:   redir_tgt = jr_addr;
      2'b10:   redir_tgt = br_target;
      2'b11:   redir_tgt = {ex_npc[31:28], j_imm, 2'b00};
      default: redir_tgt = pc_plus4;
    endcase
    redir_tgt[1:0] = 2'b00;
  end

  // Saturating increment of the no-progress counter.
  always_comb begin
    cnt_sat_inc = cnt_q;
    if (cnt_q != {CNT_W{1'b1}}) cnt_sat_inc = cnt_q + CNT_W'(1);
  end

  // Next-state logic following the per-cycle event priority.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (state_q == FETCH) begin
      if (halt) begin
        state_d = HALTED;
        instr_d = '0;
        npc_d   = '0;
        valid_d = 1'b0;
      end else if (mem_stall) begin
        cnt_d = cnt_sat_inc;
      end else if (pcsrc != 2'b00) begin
        pc_d    = redir_tgt;
        instr_d = '0;
        npc_d   = '0;
        valid_d = 1'b0;
      end else if (lw_nop) begin
        cnt_d = cnt_sat_inc;
      end else if (imem.ihit) begin
        pc_d    = pc_plus4;
        instr_d = imem.iload;
        npc_d   = pc_plus4;
        valid_d = 1'b1;
      end else begin
        instr_d = '0;
        npc_d   = '0;
        valid_d = 1'b0;
        cnt_d   = cnt_sat_inc;
      end
    end
  end

  // State and pipeline-latch registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      instr_q <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios then random traffic.
module tb_fetch_unit;
  localparam logic [31:0] PC_INIT = 32'h0000_0000;
  localparam int unsigned CNT_W   = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             mem_stall, lw_nop, halt;
  logic [1:0]       pcsrc;
  logic [31:0]      jr_addr, br_target, ex_npc;
  logic [25:0]      j_imm;
  logic [31:0]      ifid_instr, ifid_npc, pc_out;
  logic             ifid_valid;
  logic [CNT_W-1:0] stall_cnt;

  fetch_unit_if bus ();

  fetch_unit #(.PC_INIT(PC_INIT), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .imem(bus),
    .mem_stall(mem_stall), .lw_nop(lw_nop), .halt(halt), .pcsrc(pcsrc),
    .jr_addr(jr_addr), .br_target(br_target), .j_imm(j_imm), .ex_npc(ex_npc),
    .ifid_instr(ifid_instr), .ifid_npc(ifid_npc), .ifid_valid(ifid_valid),
    .pc_out(pc_out), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] npc;
    logic        valid;
    int          cnt;
    logic        ren;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  // Reference state: what the fetch stage should hold after each edge.
  logic [31:0] m_pc    = PC_INIT;
  logic [31:0] m_instr = 0;
  logic [31:0] m_npc   = 0;
  logic        m_valid = 0;
  int          m_cnt   = 0;
  bit          m_halted = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endfunction

  task automatic step(input bit r, input bit ih, input bit ms, input bit lw, input bit hl,
                      input logic [1:0] ps, input logic [31:0] jr, input logic [31:0] br,
                      input logic [25:0] ji, input logic [31:0] en);
    exp_t e;
    logic [31:0] tgt;
    @(negedge clk);
    rst = r; bus.ihit = ih; mem_stall = ms; lw_nop = lw; halt = hl; pcsrc = ps;
    jr_addr = jr; br_target = br; j_imm = ji; ex_npc = en;
    bus.iload = mem_word(m_pc);
    case (ps)
      2'd1:    tgt = jr;
      2'd2:    tgt = br;
      default: tgt = {en[31:28], ji, 2'b00};
    endcase
    tgt = tgt & 32'hFFFF_FFFC;
    if (r) begin
      m_pc = PC_INIT; m_halted = 0; m_instr = 0; m_npc = 0; m_valid = 0; m_cnt = 0;
    end else if (m_halted) begin
      // frozen until reset
    end else if (hl) begin
      m_halted = 1; m_instr = 0; m_valid = 0;
    end else if (ms) begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else if (ps != 2'd0) begin
      m_pc = tgt; m_instr = 0; m_valid = 0;
    end else if (lw) begin
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end else if (ih) begin
      m_instr = mem_word(m_pc); m_npc = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
    end else begin
      m_instr = 0; m_valid = 0;
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
    end
    e.pc = m_pc; e.instr = m_instr; e.npc = m_npc; e.valid = m_valid;
    e.cnt = m_cnt; e.ren = !m_halted;
    sb.push_back(e);
  endtask

  task automatic hit(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
  endtask

  // Monitor: after every edge, compare DUT outputs with the oldest expectation.
  exp_t got;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        got = sb.pop_front();
        check("pc_out", pc_out, got.pc);
        check("imemaddr", bus.imemaddr, got.pc);
        check("imemREN", 32'(bus.imemREN), 32'(got.ren));
        check("ifid_valid", 32'(ifid_valid), 32'(got.valid));
        check("ifid_instr", ifid_instr, got.instr);
        if (got.valid) check("ifid_npc", ifid_npc, got.npc);
        check("stall_cnt", 32'(stall_cnt), 32'(got.cnt));
      end
    end
  end

  initial begin
    rst = 1; bus.ihit = 0; bus.iload = 0; mem_stall = 0; lw_nop = 0; halt = 0;
    pcsrc = 0; jr_addr = 0; br_target = 0; j_imm = 0; ex_npc = 0;

    // Reset then sequential fetch with a two-cycle load-use stall at pc=8.
    step(1, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    hit(2);
    step(0, 1, 0, 1, 0, 2'd0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 2'd0, 0, 0, 0, 0);
    hit(2);
    // Jump to 0x40, then J with region bits from ex_npc.
    step(0, 1, 0, 0, 0, 2'd1, 32'h40, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2'd3, 0, 0, 26'h10, 32'h9000_0044);
    hit(1);
    // Branch held through a three-cycle memory stall, unaligned target.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 0, 2'd2, 0, 32'h103, 0, 0);
    step(0, 1, 0, 0, 0, 2'd2, 0, 32'h103, 0, 0);
    hit(1);
    // No-hit bubble, then PC wraparound at the top of the address space.
    step(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 2'd1, 32'hFFFF_FFFF, 0, 0, 0);
    hit(2);
    // Halt, hits ignored, reset recovers.
    step(0, 1, 0, 0, 1, 2'd0, 0, 0, 0, 0);
    hit(3);
    step(1, 1, 0, 0, 0, 2'd0, 0, 0, 0, 0);
    hit(2);
    // Reset wins over a pending redirect and stall.
    step(1, 1, 1, 1, 0, 2'd2, 0, 32'h500, 0, 0);
    // Counter saturation: long no-hit run.
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 2'd0, 0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 40) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 6) == 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 60) == 0),
           ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
           $urandom, $urandom, 26'($urandom), $urandom);
    end

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage and IF/ID pipeline latch of the pipelined MIPS core. It owns the program counter and issues instruction-memory reads. It consumes the hazard unit's load-use stall and the EX-stage PC-source decision, inserting bubbles or redirecting the PC as required. Its registered outputs feed the decode stage directly.

## Interface
- PC_INIT, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the saturating stall-cycle counter
- Clocking: one clock, CLK. Reset RST is synchronous and active-high.
- CLK  in  1  core clock; all state updates on rising edge
- RST  in  1  synchronous active-high reset
- ihit  in  1  instruction memory returned data for imemaddr this cycle
- iload  in  32  instruction word, valid when ihit=1
- imemREN  out  1  instruction read enable
- imemaddr  out  32  read address; always equals pc
- mem_stall  in  1  data-memory stall; freezes entire stage
- lw_nop  in  1  load-use stall from hazard unit
- halt  in  1  halt instruction reached; stops fetching
- pcsrc  in  2  EX-stage PC source: 00 PC+4, 01 JR, 10 taken branch, 11 J/JAL
- jr_addr  in  32  JR target (register value)
- br_target  in  32  branch target
- j_imm  in  26  jump immediate
- ex_npc  in  32  PC+4 of the instruction in EX; upper 4 bits form the J region
- ifid_instr  out  32  latched instruction (0 = NOP bubble)
- ifid_npc  out  32  latched PC+4
- ifid_valid  out  1  latch holds a real instruction
- pc_out  out  32  current PC
- stall_cnt  out  CNT_W  cycles spent without advancing, saturating

## Operation
- FSM states: FETCH, HALTED. In FETCH, imemREN=1. In HALTED, imemREN=0.
- Per-cycle priority, highest first: RST > halt > mem_stall > redirect (pcsrc!=00) > lw_nop > ihit > no-hit.
- RST: pc<=PC_INIT, state<=FETCH, ifid_instr/ifid_npc<=0, ifid_valid<=0, stall_cnt<=0.
- halt: state<=HALTED; latch cleared to bubble. Only RST leaves HALTED; pc frozen in HALTED.
- mem_stall: pc, latch and state held; pending redirect is applied on the first non-stalled cycle because pcsrc is held by EX.
- Redirect: pc<=target; latch cleared to bubble (ifid_valid=0, ifid_instr=0); any ihit this cycle is discarded. Targets:
  - 01: jr_addr
  - 10: br_target
  - 11: {ex_npc[31:28], j_imm, 2'b00}
  - Bits [1:0] of every target are forced to 0.
- lw_nop: pc and latch held unchanged; ihit data discarded.
- ihit with no higher event: ifid_instr<=iload, ifid_npc<=pc+4, ifid_valid<=1, pc<=pc+4.
- No ihit: pc held; latch becomes bubble.
- pc+4 is modulo 2^32: 32'hFFFF_FFFC wraps to 0.
- stall_cnt increments on every FETCH-state cycle that does not advance pc (mem_stall, lw_nop, no-hit). It holds at 2^CNT_W-1. Redirect cycles are not counted.

## Timing
- imemaddr and imemREN are combinational from pc and state. All other outputs are registered.
- Fetch latency: instruction at pc appears on ifid_instr the edge after ihit=1.
- Redirect penalty: a redirect sampled at edge N gives imemaddr=target in cycle N+1. The first valid target instruction is latched at the earliest edge N+2.
- lw_nop for k cycles holds the latch for exactly k edges. Decode sees the same instruction k+1 cycles.
- Reset mid-stall or mid-redirect: RST wins. The next cycle has pc=PC_INIT, imemREN=1, ifid_valid=0.

## Test plan
- Reset, then ihit=1 continuously with iload=pc-indexed words → pc 0,4,8,12. The ifid_instr sequence matches, with ifid_npc 4,8,12.
- At pc=8, assert lw_nop for 2 cycles with ihit=1 → pc stays 8 for 2 edges and latch unchanged. Then pc goes 8→12 and stall_cnt=2.
- At pc=0x40, apply pcsrc=11, ex_npc=0x9000_0044, j_imm=0x10 → next pc=0x9000_0040 and ifid_valid=0 for one edge.
- Apply pcsrc=10 with br_target=0x103 together with mem_stall=1 for 3 cycles → pc frozen. It becomes 0x100 on the first non-stalled edge.
- Set pc=0xFFFF_FFFC with ihit=1 → pc wraps to 0 and ifid_npc=0.
- Assert halt, then ihit=1 → imemREN=0, pc frozen, ifid_valid=0. Asserting RST restores pc=PC_INIT and state FETCH.
